// File: rtl/encode_pkg.sv
// Shared constants and helpers for the encoder MAC datapath.
// Combinational only: no latency, no flow control.
package encode_pkg;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;
  localparam int SAT_W_MAX     = 128;

  // Sideband travelling alongside each product; first/last are pre-qualified by vld.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } side_t;

  // Largest positive two's-complement value of width w, zero-extended to SAT_W_MAX.
  function automatic logic [SAT_W_MAX-1:0] sat_max(input int w);
    logic [SAT_W_MAX-1:0] one;
    one = SAT_W_MAX'(1);
    return (one << (w - 1)) - one;
  endfunction

  // Most negative value of width w; the low w bits are 100..0.
  function automatic logic [SAT_W_MAX-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/encode_mul_pipe.sv
// Exact signed product in a NUM_STAGE-deep ce-gated register chain with valid/first/last sideband.
// Latency NUM_STAGE ce=1 cycles; no backpressure, ce=0 freezes every stage.
module encode_mul_pipe
  import encode_pkg::*;
#(
  parameter int din0_WIDTH  = 40,
  parameter int din1_WIDTH  = 23,
  parameter int dout_WIDTH  = 72,
  parameter int NUM_STAGE   = 2,
  parameter int DIN1_SIGNED = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic [din0_WIDTH-1:0]        din0,
  input  logic [din1_WIDTH-1:0]        din1,
  input  logic                         first,
  input  logic                         last,
  output logic signed [dout_WIDTH-1:0] prod,
  output side_t                        side
);

  localparam int BW = din1_WIDTH + ((DIN1_SIGNED != 0) ? 0 : 1);
  localparam int PW = din0_WIDTH + BW;

  logic signed [BW-1:0]         b_ext;
  logic signed [PW-1:0]         prod_full;
  logic signed [dout_WIDTH-1:0] prod_q [NUM_STAGE];
  side_t                        side_q [NUM_STAGE];
  side_t                        side_in;

  if (DIN1_SIGNED != 0) begin : g_b_signed
    assign b_ext = $signed(din1);
  end else begin : g_b_unsigned
    assign b_ext = $signed({1'b0, din1});
  end

  // PW bits always hold the exact product, and PW <= dout_WIDTH is enforced by the top.
  assign prod_full = PW'($signed(din0)) * PW'(b_ext);

  assign side_in = '{vld: in_valid, first: in_valid & first, last: in_valid & last};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= '0;
        side_q[i] <= '0;
      end
    end else if (ce) begin
      prod_q[0] <= dout_WIDTH'(prod_full);
      side_q[0] <= side_in;
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i] <= prod_q[i-1];
        side_q[i] <= side_q[i-1];
      end
    end
  end

  assign prod = prod_q[NUM_STAGE-1];
  assign side = side_q[NUM_STAGE-1];

endmodule

// File: rtl/encode_mac_pipe.sv
// Pipelined multiply feeding a saturating, frame-delimited accumulator; one result per frame.
// Latency NUM_STAGE+1 ce=1 cycles, 1 item/cycle; no backpressure, ce=0 freezes all state and outputs.
module encode_mac_pipe
  import encode_pkg::*;
#(
  parameter int din0_WIDTH  = 40,
  parameter int din1_WIDTH  = 23,
  parameter int dout_WIDTH  = 72,
  parameter int NUM_STAGE   = 2,
  parameter int DIN1_SIGNED = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic [din0_WIDTH-1:0]        din0,
  input  logic [din1_WIDTH-1:0]        din1,
  input  logic                         first,
  input  logic                         last,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         dout_vld,
  output logic                         ovf
);

  if (din0_WIDTH + din1_WIDTH + ((DIN1_SIGNED != 0) ? 0 : 1) > dout_WIDTH) begin : g_err_width
    $error("encode_mac_pipe: product does not fit in dout_WIDTH");
  end
  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_err_stage
    $error("encode_mac_pipe: NUM_STAGE must be 1..4");
  end
  if (dout_WIDTH > SAT_W_MAX) begin : g_err_sat
    $error("encode_mac_pipe: dout_WIDTH exceeds saturation helper range");
  end

  localparam logic signed [dout_WIDTH-1:0] SAT_HI = dout_WIDTH'(sat_max(dout_WIDTH));
  localparam logic signed [dout_WIDTH-1:0] SAT_LO = dout_WIDTH'(sat_min(dout_WIDTH));

  logic signed [dout_WIDTH-1:0] prod;
  side_t                        side;
  logic signed [dout_WIDTH-1:0] acc;
  logic signed [dout_WIDTH-1:0] acc_nxt;
  logic signed [dout_WIDTH-1:0] sat_sum;
  logic signed [dout_WIDTH:0]   sum_w;
  logic                         sat;
  logic                         sat_nxt;
  logic                         clip;

  encode_mul_pipe #(
    .din0_WIDTH (din0_WIDTH),
    .din1_WIDTH (din1_WIDTH),
    .dout_WIDTH (dout_WIDTH),
    .NUM_STAGE  (NUM_STAGE),
    .DIN1_SIGNED(DIN1_SIGNED)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .in_valid(in_valid),
    .din0    (din0),
    .din1    (din1),
    .first   (first),
    .last    (last),
    .prod    (prod),
    .side    (side)
  );

  // One guard bit: the two top bits disagree exactly when the true sum is out of range.
  assign sum_w   = {acc[dout_WIDTH-1], acc} + {prod[dout_WIDTH-1], prod};
  assign clip    = sum_w[dout_WIDTH] ^ sum_w[dout_WIDTH-1];
  assign sat_sum = clip ? (sum_w[dout_WIDTH] ? SAT_LO : SAT_HI) : sum_w[dout_WIDTH-1:0];

  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat;
    if (side.vld) begin
      if (side.first) begin
        acc_nxt = prod;
        sat_nxt = 1'b0;
      end else begin
        acc_nxt = sat_sum;
        sat_nxt = sat | clip;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      sat      <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (ce) begin
      acc      <= acc_nxt;
      sat      <= sat_nxt;
      dout_vld <= side.last;
      if (side.last) begin
        dout <= acc_nxt;
        ovf  <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_encode_mac_pipe.sv
// Bench for encode_mac_pipe: three instances (default, narrow 8x7->16, signed din1), vector table plus hand sequences.
module tb_encode_mac_pipe;

  typedef struct {
    int     inst;
    longint a;
    longint b;
    bit     f;
    bit     l;
    longint exp_d;
    bit     exp_o;
  } vec_t;

  typedef struct {
    logic signed [71:0] d;
    logic               o;
    int                 cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic [2:0]  iv = '0;
  logic [39:0] din0 = '0;
  logic [22:0] din1 = '0;
  logic        first = 1'b0;
  logic        last = 1'b0;

  logic signed [71:0] d0, d2;
  logic signed [15:0] d1;
  logic [7:0]  din0_s;
  logic [6:0]  din1_s;
  logic        v0, v1, v2, o0, o1, o2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q [3][$];
  vec_t vecs [$];

  assign din0_s = din0[7:0];
  assign din1_s = din1[6:0];

  always #5 clk = ~clk;
  always @(posedge clk) if (ce) cyc++;

  encode_mac_pipe #(.din0_WIDTH(40), .din1_WIDTH(23), .dout_WIDTH(72), .NUM_STAGE(2), .DIN1_SIGNED(0)) u_dut (
    .clk(clk), .reset(rst), .ce(ce), .in_valid(iv[0]), .din0(din0), .din1(din1),
    .first(first), .last(last), .dout(d0), .dout_vld(v0), .ovf(o0));

  encode_mac_pipe #(.din0_WIDTH(8), .din1_WIDTH(7), .dout_WIDTH(16), .NUM_STAGE(2), .DIN1_SIGNED(0)) u_small (
    .clk(clk), .reset(rst), .ce(ce), .in_valid(iv[1]), .din0(din0_s), .din1(din1_s),
    .first(first), .last(last), .dout(d1), .dout_vld(v1), .ovf(o1));

  encode_mac_pipe #(.din0_WIDTH(40), .din1_WIDTH(23), .dout_WIDTH(72), .NUM_STAGE(2), .DIN1_SIGNED(1)) u_sgn (
    .clk(clk), .reset(rst), .ce(ce), .in_valid(iv[2]), .din0(din0), .din1(din1),
    .first(first), .last(last), .dout(d2), .dout_vld(v2), .ovf(o2));

  task automatic chk(input string nm, input logic signed [71:0] act, input logic signed [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse(input int inst, input logic signed [71:0] d, input logic o);
    exp_t e;
    if (q[inst].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse inst=%0d: got dout_vld=1 expected 0 (dout=%0d)", inst, d);
      return;
    end
    e = q[inst].pop_front();
    chk($sformatf("dout inst%0d", inst), d, e.d);
    chk($sformatf("ovf inst%0d", inst), {71'b0, o}, {71'b0, e.o});
    chk($sformatf("latency inst%0d", inst), 72'(cyc), 72'(e.cyc));
  endtask

  // Scoreboard consumer: a result is taken only on ce-qualified cycles.
  always @(negedge clk) begin
    if (!rst && ce) begin
      if (v0) pulse(0, d0, o0);
      if (v1) pulse(1, d1, o1);
      if (v2) pulse(2, d2, o2);
    end
  end

  task automatic drive(input int inst, input longint a, input longint b, input bit f, input bit l);
    @(posedge clk); #1;
    iv = '0;
    iv[inst] = 1'b1;
    din0 = a[39:0];
    din1 = b[22:0];
    first = f;
    last = l;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    iv = '0;
    first = 1'b0;
    last = 1'b0;
  endtask

  task automatic expect_res(input int inst, input longint d, input bit o);
    exp_t e;
    e.d = d;
    e.o = o;
    e.cyc = cyc + 3;
    q[inst].push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // Main instance: item before any first, single item, 4-item frame, first reopening a frame, back-to-back singles
    vecs.push_back('{0, 2, 3, 0, 0, 0, 0});
    vecs.push_back('{0, 4, 5, 0, 1, 26, 0});
    vecs.push_back('{0, -3, 5, 1, 1, -15, 0});
    vecs.push_back('{0, 1000, 3, 1, 0, 0, 0});
    vecs.push_back('{0, 2000, 3, 0, 0, 0, 0});
    vecs.push_back('{0, -500, 3, 0, 0, 0, 0});
    vecs.push_back('{0, 7, 3, 0, 1, 7521, 0});
    vecs.push_back('{0, 100, 1, 1, 0, 0, 0});
    vecs.push_back('{0, 50, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 9, 1, 1, 1, 9, 0});
    vecs.push_back('{0, 2, 2, 1, 1, 4, 0});
    vecs.push_back('{0, -7, 3, 1, 1, -21, 0});
    vecs.push_back('{0, 5, 23'h7FFFFF, 1, 1, 41943035, 0});
    // Narrow instance: positive clamp, clean restart, negative clamp, sticky flag after recovery
    vecs.push_back('{1, 127, 127, 1, 0, 0, 0});
    vecs.push_back('{1, 127, 127, 0, 0, 0, 0});
    vecs.push_back('{1, 127, 127, 0, 1, 32767, 1});
    vecs.push_back('{1, 1, 1, 1, 1, 1, 0});
    vecs.push_back('{1, -128, 127, 1, 0, 0, 0});
    vecs.push_back('{1, -128, 127, 0, 0, 0, 0});
    vecs.push_back('{1, -128, 127, 0, 1, -32768, 1});
    vecs.push_back('{1, 127, 127, 1, 0, 0, 0});
    vecs.push_back('{1, 127, 127, 0, 0, 0, 0});
    vecs.push_back('{1, 127, 127, 0, 0, 0, 0});
    vecs.push_back('{1, -128, 127, 0, 1, 16511, 1});
    // Signed-din1 instance
    vecs.push_back('{2, 2, 2, 1, 1, 4, 0});
    vecs.push_back('{2, -7, 3, 1, 1, -21, 0});
    vecs.push_back('{2, 5, -1, 1, 1, -5, 0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset dout0", d0, 0);
    chk("reset vld0", {71'b0, v0}, 0);
    chk("reset ovf0", {71'b0, o0}, 0);
    chk("reset dout1", d1, 0);
    chk("reset vld1", {71'b0, v1}, 0);
    chk("reset dout2", d2, 0);
    chk("reset vld2", {71'b0, v2}, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].inst, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].l);
      if (vecs[i].l) expect_res(vecs[i].inst, vecs[i].exp_d, vecs[i].exp_o);
    end
    idle();
    repeat (6) @(posedge clk);

    // ce stall mid-frame: result delayed by the stall, single pulse
    drive(0, 1000, 3, 1, 0);
    drive(0, 2000, 3, 0, 0);
    @(posedge clk); #1;
    iv = '0;
    ce = 1'b0;
    repeat (5) @(posedge clk);
    #1 ce = 1'b1;
    drive(0, -500, 3, 0, 0);
    drive(0, 7, 3, 0, 1);
    expect_res(0, 7521, 0);
    idle();
    repeat (6) @(posedge clk);

    // dout_vld held while ce=0
    drive(0, 6, 7, 1, 1);
    expect_res(0, 42, 0);
    idle();
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk); #1;
      if (v0) found = 1'b1;
    end
    chk("hold pulse seen", {71'b0, found}, 1);
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("hold vld", {71'b0, v0}, 1);
      chk("hold dout", d0, 42);
    end
    ce = 1'b1;
    @(negedge clk); #1;
    chk("vld drops after hold", {71'b0, v0}, 0);
    repeat (4) @(posedge clk);

    // Mid-frame reset discards the frame and clears the accumulator
    drive(0, 10, 1, 1, 0);
    drive(0, 20, 1, 0, 0);
    @(posedge clk); #1;
    iv = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset dout", d0, 0);
    chk("midreset vld", {71'b0, v0}, 0);
    rst = 1'b0;
    drive(0, 4, 4, 0, 1);
    expect_res(0, 16, 0);
    idle();
    repeat (8) @(posedge clk);

    for (int k = 0; k < 3; k++)
      chk($sformatf("pending results inst%0d", k), 72'(q[k].size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
